// File: rtl/io_cpx_reqq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_cpx_reqq_pkg
// Description : Shared IOP/CPX constants, queue entry type, issue FSM states
//               and a one-hot helper for the IO CPX request queue.
// Revision    : 1.0 - initial release
// ============================================================================
package io_cpx_reqq_pkg;

  localparam int CPX_WIDTH      = 145;
  localparam int IO_CPX_MAX_OUT = 2;
  localparam int CORE_ID_W      = 3;
  localparam int NUM_CORES      = 1 << CORE_ID_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } iss_state_e;

  typedef struct packed {
    logic [CORE_ID_W-1:0] dest;
    logic [CPX_WIDTH-1:0] data;
  } cpx_entry_t;

  // One-hot core select from a core id.
  function automatic logic [NUM_CORES-1:0] dest_onehot(input logic [CORE_ID_W-1:0] dest);
    dest_onehot       = '0;
    dest_onehot[dest] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_cpx_outcnt.sv
`default_nettype none
// ============================================================================
// Module      : io_cpx_outcnt
// Description : Outstanding-request counter for one CPX destination core.
//               Counts issued-but-ungranted packets; flags grants that arrive
//               while nothing is outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module io_cpx_outcnt #(
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_err
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Next count: issue and grant together cancel; a grant at zero is dropped.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_inc && !i_dec) begin
      if (r_cnt != CNT_W'(MAX_OUT)) w_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (i_dec && !i_inc) begin
      if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) r_cnt <= '0;
    else         r_cnt <= w_cnt_nxt;
  end

  assign o_cnt = r_cnt;
  assign o_err = i_dec && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/io_cpx_reqq.sv
`default_nettype none
// ============================================================================
// Module      : io_cpx_reqq
// Description : IO-to-CPX source request queue. 4-deep in-order FIFO, one-hot
//               cq-stage request, ca-stage data, per-core outstanding limit.
//               Optional macro IO_CPX_REQQ_STALL_CNT_EN adds io_cpx_stall_cnt,
//               a saturating count of head-blocked cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module io_cpx_reqq
  import io_cpx_reqq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = IO_CPX_MAX_OUT
) (
  input  logic                 rclk,
  input  logic                 arst_l,
  input  logic                 iob_cpx_vld,
  input  logic [CORE_ID_W-1:0] iob_cpx_dest,
  input  logic [CPX_WIDTH-1:0] iob_cpx_data,
  output logic                 iob_cpx_full,
  output logic [NUM_CORES-1:0] io_cpx_req_cq,
  output logic [CPX_WIDTH-1:0] io_cpx_data_ca,
  input  logic [NUM_CORES-1:0] cpx_io_grant_ca,
`ifdef IO_CPX_REQQ_STALL_CNT_EN
  output logic [15:0]          io_cpx_stall_cnt,
`endif
  output logic                 io_cpx_grant_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  cpx_entry_t               r_mem [DEPTH];
  logic [PTR_W-1:0]         r_wptr;
  logic [PTR_W-1:0]         r_rptr;
  logic                     r_full;
  iss_state_e               r_state;
  iss_state_e               w_state_nxt;
  logic [CORE_ID_W-1:0]     r_req_dest;
  logic [CPX_WIDTH-1:0]     r_data_cq;
  logic [CPX_WIDTH-1:0]     r_data_ca;
  logic                     r_err;

  logic                     w_empty;
  logic                     w_push;
  logic                     w_issue;
  logic                     w_head_blk;
  cpx_entry_t               w_head;
  logic [PTR_W-1:0]         w_wptr_nxt;
  logic [PTR_W-1:0]         w_rptr_nxt;
  logic                     w_full_nxt;
  logic [NUM_CORES-1:0]     w_inc;
  logic [NUM_CORES-1:0]     w_at_max;
  logic [NUM_CORES-1:0]     w_err_vec;
  logic [CNT_W-1:0]         w_out_cnt [NUM_CORES];

  assign w_empty    = (r_wptr == r_rptr);
  assign w_head     = r_mem[r_rptr[IDX_W-1:0]];
  assign w_head_blk = w_at_max[w_head.dest];
  assign w_push     = iob_cpx_vld && !r_full;
  assign w_issue    = !w_empty && !w_head_blk;
  assign w_wptr_nxt = r_wptr + PTR_W'(w_push);
  assign w_rptr_nxt = r_rptr + PTR_W'(w_issue);
  assign w_full_nxt = (w_wptr_nxt[IDX_W] != w_rptr_nxt[IDX_W]) &&
                      (w_wptr_nxt[IDX_W-1:0] == w_rptr_nxt[IDX_W-1:0]);

  // Per-core outstanding counters; blocking is judged on registered counts,
  // so a grant this cycle only frees the slot for the next cycle.
  generate
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_outcnt
      io_cpx_outcnt #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
      ) u_outcnt (
        .rclk   (rclk),
        .arst_l (arst_l),
        .i_inc  (w_inc[g]),
        .i_dec  (cpx_io_grant_ca[g]),
        .o_cnt  (w_out_cnt[g]),
        .o_err  (w_err_vec[g])
      );
      assign w_at_max[g] = (w_out_cnt[g] == CNT_W'(MAX_OUT));
    end
  endgenerate

  // FIFO storage write; contents need no reset because pointers gate reads.
  always_ff @(posedge rclk) begin
    if (w_push) r_mem[r_wptr[IDX_W-1:0]] <= '{dest: iob_cpx_dest, data: iob_cpx_data};
  end

  // FIFO pointers and registered full flag.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_full <= 1'b0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
      r_full <= w_full_nxt;
    end
  end

  // Issue FSM next state and counter increment strobes.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_inc       = '0;
    if (w_issue) begin
      w_state_nxt = ST_ISSUE;
      w_inc       = dest_onehot(w_head.dest);
    end
  end

  // Issue FSM state plus cq-stage request/data capture.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state    <= ST_IDLE;
      r_req_dest <= '0;
      r_data_cq  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_req_dest <= w_head.dest;
        r_data_cq  <= w_head.data;
      end
    end
  end

  // ca-stage data follows the request by one cycle and otherwise holds.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l)                 r_data_ca <= '0;
    else if (r_state == ST_ISSUE) r_data_ca <= r_data_cq;
  end

  // Sticky error for grants with nothing outstanding.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) r_err <= 1'b0;
    else         r_err <= r_err || (|w_err_vec);
  end

`ifdef IO_CPX_REQQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles the head waits on its core's outstanding limit.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l)
      r_stall_cnt <= '0;
    else if (!w_empty && w_head_blk && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign io_cpx_stall_cnt = r_stall_cnt;
`endif

  assign iob_cpx_full     = r_full;
  assign io_cpx_req_cq    = (r_state == ST_ISSUE) ? dest_onehot(r_req_dest) : '0;
  assign io_cpx_data_ca   = r_data_ca;
  assign io_cpx_grant_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_io_cpx_reqq.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_cpx_reqq
// Description : Self-checking bench for io_cpx_reqq: directed steps with an
//               in-order scoreboard of expected request/data pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_cpx_reqq;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0]   dest;
    logic [144:0] data;
  } ent_t;

  logic         clk;
  logic         arst_l;
  logic         iob_cpx_vld;
  logic [2:0]   iob_cpx_dest;
  logic [144:0] iob_cpx_data;
  logic         iob_cpx_full;
  logic [7:0]   io_cpx_req_cq;
  logic [144:0] io_cpx_data_ca;
  logic [7:0]   cpx_io_grant_ca;
  logic         io_cpx_grant_err;
`ifdef IO_CPX_REQQ_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  int checks    = 0;
  int errors    = 0;
  int model_cnt = 0;
  int issue_cnt = 0;
  ent_t         sb_q [$];
  logic [144:0] exp_data  = '0;
  logic [144:0] pend_data = '0;
  logic         pend_vld  = 1'b0;

  io_cpx_reqq dut (
    .rclk             (clk),
    .arst_l           (arst_l),
    .iob_cpx_vld      (iob_cpx_vld),
    .iob_cpx_dest     (iob_cpx_dest),
    .iob_cpx_data     (iob_cpx_data),
    .iob_cpx_full     (iob_cpx_full),
    .io_cpx_req_cq    (io_cpx_req_cq),
    .io_cpx_data_ca   (io_cpx_data_ca),
    .cpx_io_grant_ca  (cpx_io_grant_ca),
`ifdef IO_CPX_REQQ_STALL_CNT_EN
    .io_cpx_stall_cnt (stall_cnt),
`endif
    .io_cpx_grant_err (io_cpx_grant_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [144:0] got, input logic [144:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] oh(input logic [2:0] d);
    oh = 8'h01 << d;
  endfunction

  function automatic logic [144:0] mk(input int n);
    mk = {17'(n), {4{32'(n) ^ 32'hA5C3_0F00}}};
  endfunction

  // Inputs change one time unit after the falling edge, well clear of rclk.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] d, input logic [144:0] v);
    ent_t e;
    chk("full_at_push", 145'(iob_cpx_full), 145'(model_cnt == DEPTH));
    iob_cpx_vld  = 1'b1;
    iob_cpx_dest = d;
    iob_cpx_data = v;
    if (model_cnt < DEPTH) begin
      e.dest = d;
      e.data = v;
      sb_q.push_back(e);
      model_cnt++;
    end
    step();
    iob_cpx_vld = 1'b0;
  endtask

  task automatic grant(input logic [7:0] g);
    cpx_io_grant_ca = g;
    step();
    cpx_io_grant_ca = 8'h00;
  endtask

  // Scoreboard monitor: every request must match the oldest accepted push,
  // and its data must appear on the ca stage exactly one cycle later.
  always @(negedge clk) begin
    ent_t e;
    if (arst_l) begin
      if (pend_vld) exp_data = pend_data;
      chk("data_ca", io_cpx_data_ca, exp_data);
      pend_vld = 1'b0;
      if (io_cpx_req_cq != 8'h00) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_req", 145'(io_cpx_req_cq), 145'(0));
        end else begin
          e = sb_q.pop_front();
          chk("req_order", 145'(io_cpx_req_cq), 145'(oh(e.dest)));
          pend_data = e.data;
          pend_vld  = 1'b1;
          model_cnt--;
          issue_cnt++;
        end
      end
    end
  end

  initial begin
    arst_l          = 1'b0;
    iob_cpx_vld     = 1'b0;
    iob_cpx_dest    = 3'd0;
    iob_cpx_data    = '0;
    cpx_io_grant_ca = 8'h00;
    step(); step();
    chk("rst_full", 145'(iob_cpx_full), 145'(0));
    chk("rst_req",  145'(io_cpx_req_cq), 145'(0));
    chk("rst_data", io_cpx_data_ca, 145'(0));
    chk("rst_err",  145'(io_cpx_grant_err), 145'(0));
    arst_l = 1'b1;
    step();

    // Single packet to core 3.
    push(3'd3, mk(1));
    chk("t1_req_before", 145'(io_cpx_req_cq), 145'(0));
    step();
    chk("t1_req", 145'(io_cpx_req_cq), 145'(8'h08));
    chk("t1_out3", 145'(dut.w_out_cnt[3]), 145'(1));
    step();
    chk("t1_req_done", 145'(io_cpx_req_cq), 145'(0));
    chk("t1_data", io_cpx_data_ca, mk(1));
    grant(8'h08);
    chk("t1_out3_clr", 145'(dut.w_out_cnt[3]), 145'(0));

    // Three packets to core 5: limit of two outstanding.
    push(3'd5, mk(10));
    push(3'd5, mk(11));
    chk("t2_req_a", 145'(io_cpx_req_cq), 145'(8'h20));
    push(3'd5, mk(12));
    chk("t2_req_b", 145'(io_cpx_req_cq), 145'(8'h20));
    step();
    chk("t2_blk_a", 145'(io_cpx_req_cq), 145'(0));
    step();
    chk("t2_blk_b", 145'(io_cpx_req_cq), 145'(0));
    chk("t2_out5", 145'(dut.w_out_cnt[5]), 145'(2));
    grant(8'h20);
    chk("t2_grant_cycle", 145'(io_cpx_req_cq), 145'(0));
    step();
    chk("t2_req_c", 145'(io_cpx_req_cq), 145'(8'h20));
    grant(8'h20);
    grant(8'h20);
    chk("t2_out5_clr", 145'(dut.w_out_cnt[5]), 145'(0));

    // Issue and grant to core 2 in the same cycle.
    push(3'd2, mk(20));
    push(3'd2, mk(21));
    chk("t4_out2_pre", 145'(dut.w_out_cnt[2]), 145'(1));
    grant(8'h04);
    chk("t4_req", 145'(io_cpx_req_cq), 145'(8'h04));
    chk("t4_out2", 145'(dut.w_out_cnt[2]), 145'(1));
    grant(8'h04);
    chk("t4_out2_clr", 145'(dut.w_out_cnt[2]), 145'(0));

    // Grants with nothing outstanding.
    chk("t5_err_pre", 145'(io_cpx_grant_err), 145'(0));
    grant(8'h81);
    chk("t5_err", 145'(io_cpx_grant_err), 145'(1));
    chk("t5_out0", 145'(dut.w_out_cnt[0]), 145'(0));
    chk("t5_out7", 145'(dut.w_out_cnt[7]), 145'(0));
    step(); step(); step();
    chk("t5_err_sticky", 145'(io_cpx_grant_err), 145'(1));

    // Reset with three entries queued behind a blocked head.
    for (int i = 0; i < 5; i++) push(3'd6, mk(30 + i));
    chk("t6_full_pre", 145'(iob_cpx_full), 145'(0));
    #2 arst_l = 1'b0;
    #1;
    chk("t6_rst_req",  145'(io_cpx_req_cq), 145'(0));
    chk("t6_rst_data", io_cpx_data_ca, 145'(0));
    chk("t6_rst_err",  145'(io_cpx_grant_err), 145'(0));
    chk("t6_rst_full", 145'(iob_cpx_full), 145'(0));
    sb_q.delete();
    model_cnt = 0;
    exp_data  = '0;
    pend_vld  = 1'b0;
    step(); step();
    arst_l = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t6_no_req", 145'(io_cpx_req_cq), 145'(0));
`ifdef IO_CPX_REQQ_STALL_CNT_EN
    chk("t6_stall_zero", 145'(stall_cnt), 145'(0));
`endif
    grant(8'h40);
    chk("t6_err_after_rst", 145'(io_cpx_grant_err), 145'(1));
    chk("t6_out6", 145'(dut.w_out_cnt[6]), 145'(0));

    // Fill behind a blocked core-0 head; fifth push dropped; in-order drain.
    push(3'd0, mk(40));
    push(3'd0, mk(41));
    push(3'd0, mk(42));
    push(3'd1, mk(43));
    push(3'd2, mk(44));
    push(3'd3, mk(45));
    chk("t3_full", 145'(iob_cpx_full), 145'(1));
    push(3'd4, mk(46));
    step(); step();
    chk("t3_still_full", 145'(iob_cpx_full), 145'(1));
    grant(8'h01);
    chk("t3_req_grant_cycle", 145'(io_cpx_req_cq), 145'(0));
`ifdef IO_CPX_REQQ_STALL_CNT_EN
    chk("t3_stall", 145'(stall_cnt), 145'(7));
`endif
    issue_cnt = 0;
    step();
    chk("t3_req0", 145'(io_cpx_req_cq), 145'(8'h01));
    chk("t3_full_clr", 145'(iob_cpx_full), 145'(0));
    step();
    chk("t3_req1", 145'(io_cpx_req_cq), 145'(8'h02));
    step();
    chk("t3_req2", 145'(io_cpx_req_cq), 145'(8'h04));
    step();
    chk("t3_req3", 145'(io_cpx_req_cq), 145'(8'h08));
    step(); step(); step();
    chk("t3_req_end", 145'(io_cpx_req_cq), 145'(0));
    chk("t3_issue_cnt", 145'(issue_cnt), 145'(4));
    chk("t3_sb_drained", 145'(sb_q.size()), 145'(0));
`ifdef IO_CPX_REQQ_STALL_CNT_EN
    chk("t3_stall_hold", 145'(stall_cnt), 145'(7));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
